// File: rtl/fetch_exec_ctrl_pkg.sv
// Shared definitions for the fetch/execute sequencer: state encoding,
// opcode classes and small instruction-decode helpers.
package fetch_exec_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_WAIT_ALU = 3'd4,
        ST_MEM      = 3'd5,
        ST_WB       = 3'd6,
        ST_HALT     = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        OP_ALU = 2'b00,
        OP_LD  = 2'b01,
        OP_ST  = 2'b10,
        OP_JMP = 2'b11
    } op_class_e;

    // ALU-class encoding reserved to stop the core
    localparam logic [7:0] HALT_CODE    = 8'h3F;
    // Jump targets stay inside the current 64-byte page of the PC
    localparam logic [7:0] PC_PAGE_MASK = 8'hC0;

    function automatic op_class_e op_class(input logic [7:0] ins);
        return op_class_e'(ins[7:6]);
    endfunction

    function automatic logic is_halt(input logic [7:0] ins);
        return (ins == HALT_CODE);
    endfunction

endpackage

// File: rtl/fetch_exec_ctrl_if.sv
// Bundle of the sequencer's handshakes with the fetch stage, the ALU,
// the data memory and the register file. The controller side uses the
// master modport; the surrounding core (or a bench) uses slave.
interface fetch_exec_ctrl_if;

    logic       run;
    logic [7:0] inscode;
    logic [7:0] pc;
    logic       alu_done;
    logic       mem_ready;

    logic       fetch_en;
    logic [7:0] jmp;
    logic [7:0] pcjmp;
    logic [7:0] ir;
    logic       alu_start;
    logic       mem_req;
    logic       mem_we;
    logic       reg_we;
    logic       halted;
    logic       fault;

    modport master (
        input  run, inscode, pc, alu_done, mem_ready,
        output fetch_en, jmp, pcjmp, ir, alu_start, mem_req, mem_we,
               reg_we, halted, fault
    );

    modport slave (
        output run, inscode, pc, alu_done, mem_ready,
        input  fetch_en, jmp, pcjmp, ir, alu_start, mem_req, mem_we,
               reg_we, halted, fault
    );

endinterface

// File: rtl/fetch_exec_ctrl_wait_timer.sv
// Watchdog for the ALU/memory wait states. Cleared on the edge that enters
// a wait state, it counts cycles spent there; expired_o is high during the
// TIMEOUT-th wait cycle. The count saturates so it never wraps.
module fetch_exec_ctrl_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Count value seen during the last permitted wait cycle
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       expired_q;

    // Next count: clear on entry, advance while waiting, hold at the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i && (count_q != LAST_CNT)) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter and registered expiry flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q   <= 8'd0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == LAST_CNT);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle sequencer of the 8-bit core. Steps FETCH/DECODE/EXEC, then
// waits on the ALU or data memory, writes back, and handles jumps, HALT and
// a sticky wait-timeout fault. Every output is a register loaded from the
// next state, so each output lines up exactly with its state cycle.
module fetch_exec_ctrl
    import fetch_exec_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                reset_i,
    fetch_exec_ctrl_if.master   bus_io
);

    state_e     state_q;
    state_e     state_d;
    logic [7:0] ir_q;
    logic [7:0] ir_d;
    logic       fault_q;
    logic       fault_d;

    logic       fetch_en_q;
    logic [7:0] jmp_q;
    logic [7:0] pcjmp_q;
    logic       alu_start_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic       reg_we_q;
    logic       halted_q;

    logic       exec_jump_s;
    logic       exec_alu_s;
    logic       timer_clear_s;
    logic       timer_en_s;
    logic       timer_expired_s;

    fetch_exec_ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_en_s),
        .expired_o (timer_expired_s)
    );

    // Next-state, instruction latch and fault decisions
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d    = bus_io.inscode;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (is_halt(ir_q)) begin
                    state_d = ST_HALT;
                end else begin
                    case (op_class(ir_q))
                        OP_ALU:  state_d = ST_WAIT_ALU;
                        OP_LD:   state_d = ST_MEM;
                        OP_ST:   state_d = ST_MEM;
                        // The jump cycle itself fetches the target
                        OP_JMP:  state_d = ST_DECODE;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_WAIT_ALU: begin
                if (bus_io.alu_done) begin
                    state_d = ST_WB;
                end else if (timer_expired_s) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_ALU;
                end
            end
            ST_MEM: begin
                if (bus_io.mem_ready) begin
                    if (op_class(ir_q) == OP_ST) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timer_expired_s) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                // A timeout fault can only be cleared by reset
                if (bus_io.run && !fault_q) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and timer-control decode for the upcoming cycle
    always_comb begin
        exec_jump_s   = (state_d == ST_EXEC) && (op_class(ir_d) == OP_JMP);
        exec_alu_s    = (state_d == ST_EXEC) && (op_class(ir_d) == OP_ALU)
                        && !is_halt(ir_d);
        timer_en_s    = (state_q == ST_WAIT_ALU) || (state_q == ST_MEM);
        timer_clear_s = ((state_d == ST_WAIT_ALU) || (state_d == ST_MEM))
                        && (state_d != state_q);
    end

    // State, instruction register, sticky fault and registered outputs.
    // pcjmp takes the PC seen in DECODE; the fetch stage holds it until the
    // jump cycle because fetch_en is low in DECODE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            ir_q        <= 8'h00;
            fault_q     <= 1'b0;
            fetch_en_q  <= 1'b0;
            jmp_q       <= 8'h00;
            pcjmp_q     <= 8'h00;
            alu_start_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            reg_we_q    <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            fault_q     <= fault_d;
            fetch_en_q  <= (state_d == ST_FETCH) || exec_jump_s;
            jmp_q       <= exec_jump_s ? {2'b11, ir_d[5:0]} : 8'h00;
            pcjmp_q     <= exec_jump_s ? (bus_io.pc & PC_PAGE_MASK) : 8'h00;
            alu_start_q <= exec_alu_s;
            mem_req_q   <= (state_d == ST_MEM);
            mem_we_q    <= (state_d == ST_MEM) && (op_class(ir_d) == OP_ST);
            reg_we_q    <= (state_d == ST_WB);
            halted_q    <= (state_d == ST_HALT);
        end
    end

    assign bus_io.fetch_en  = fetch_en_q;
    assign bus_io.jmp       = jmp_q;
    assign bus_io.pcjmp     = pcjmp_q;
    assign bus_io.ir        = ir_q;
    assign bus_io.alu_start = alu_start_q;
    assign bus_io.mem_req   = mem_req_q;
    assign bus_io.mem_we    = mem_we_q;
    assign bus_io.reg_we    = reg_we_q;
    assign bus_io.halted    = halted_q;
    assign bus_io.fault     = fault_q;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Bench for fetch_exec_ctrl. A cycle-trace model builds the expected output
// of every cycle from the instruction's class and the done/ready delay the
// bench chooses, while irrelevant inputs carry random noise.
module tb_fetch_exec_ctrl;

    localparam int TIMEOUT = 15;
    localparam int MD_IDLE   = 0;
    localparam int MD_FETCH  = 1;
    localparam int MD_DECODE = 2;
    localparam int MD_HALT   = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_exec_ctrl_if bus ();

    fetch_exec_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         mode;
    logic [7:0] m_ir;
    bit         m_fault;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %08h expected %08h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit fe, input bit as_, input bit mr,
                                         input bit mw, input bit rw, input bit h,
                                         input bit f, input logic [7:0] j,
                                         input logic [7:0] pj, input logic [7:0] ir);
        return {1'b0, fe, as_, mr, mw, rw, h, f, j, pj, ir};
    endfunction

    // Expected output word for this cycle given the model's ir and fault
    function automatic logic [31:0] ev(input bit fe, input bit as_, input bit mr,
                                       input bit mw, input bit rw, input bit h,
                                       input logic [7:0] j, input logic [7:0] pj);
        return pack(fe, as_, mr, mw, rw, h, m_fault, j, pj, m_ir);
    endfunction

    function automatic logic [31:0] quiet();
        return ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic logic [7:0] rbyte();
        return 8'($urandom);
    endfunction

    // One clock cycle: check this cycle's outputs, then drive its inputs
    task automatic cyc(input string tag, input bit rst, input bit run,
                       input logic [7:0] ins, input logic [7:0] pcv,
                       input bit done, input bit rdy, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check_eq(tag, pack(bus.fetch_en, bus.alu_start, bus.mem_req, bus.mem_we,
                           bus.reg_we, bus.halted, bus.fault, bus.jmp, bus.pcjmp,
                           bus.ir), exp);
        reset         = rst;
        bus.run       = run;
        bus.inscode   = ins;
        bus.pc        = pcv;
        bus.alu_done  = done;
        bus.mem_ready = rdy;
    endtask

    task automatic idle_phase(input int n_wait);
        for (int i = 0; i < n_wait; i++)
            cyc("idle", 1'b0, 1'b0, rbyte(), rbyte(), rb(), rb(), quiet());
        cyc("idle_go", 1'b0, 1'b1, rbyte(), rbyte(), rb(), rb(), quiet());
        mode = MD_FETCH;
    endtask

    task automatic fetch_phase();
        cyc("fetch", 1'b0, rb(), rbyte(), rbyte(), rb(), rb(),
            ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
    endtask

    task automatic halt_phase(input int n_wait);
        for (int i = 0; i < n_wait; i++)
            cyc("halt", 1'b0, 1'b0, rbyte(), rbyte(), rb(), rb(),
                ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
        cyc("halt_run", 1'b0, 1'b1, rbyte(), rbyte(), rb(), rb(),
            ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
        mode = MD_FETCH;
    endtask

    // Faulted HALT ignores run; only reset brings the core back to IDLE
    task automatic fault_recover();
        for (int i = 0; i < 3; i++)
            cyc("fault_run", 1'b0, 1'b1, rbyte(), rbyte(), rb(), rb(),
                ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
        cyc("fault_rst", 1'b1, 1'b0, rbyte(), rbyte(), rb(), rb(),
            ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00));
        m_ir    = 8'h00;
        m_fault = 1'b0;
        mode    = MD_IDLE;
    endtask

    // DECODE through completion of one instruction. w = wait cycles before
    // done/ready; rst_at = wait cycle in which reset is raised (0 = never).
    task automatic exec_instr(input logic [7:0] ins, input logic [7:0] pcv,
                              input int w, input int rst_at);
        logic [1:0] cls;
        bit         st;
        int         n_wait;
        cls = ins[7:6];
        st  = (cls == 2'b10);
        cyc("decode", 1'b0, rb(), ins, pcv, rb(), rb(), quiet());
        m_ir = ins;
        if (ins == 8'h3F) begin
            cyc("exec_halt", 1'b0, rb(), rbyte(), pcv, rb(), rb(), quiet());
            mode = MD_HALT;
            return;
        end
        if (cls == 2'b11) begin
            cyc("exec_jmp", 1'b0, rb(), rbyte(), pcv, rb(), rb(),
                ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {2'b11, ins[5:0]},
                   {pcv[7:6], 6'b000000}));
            mode = MD_DECODE;
            return;
        end
        if (cls == 2'b00)
            cyc("exec_alu", 1'b0, rb(), rbyte(), pcv, rb(), rb(),
                ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00));
        else
            cyc("exec_mem", 1'b0, rb(), rbyte(), pcv, rb(), rb(), quiet());
        n_wait = (w + 1 > TIMEOUT) ? TIMEOUT : w + 1;
        for (int i = 1; i <= n_wait; i++) begin
            if (cls == 2'b00)
                cyc("wait_alu", i == rst_at, rb(), rbyte(), pcv, i == w + 1, rb(),
                    quiet());
            else
                cyc(st ? "mem_st" : "mem_ld", i == rst_at, rb(), rbyte(), pcv, rb(),
                    i == w + 1,
                    ev(1'b0, 1'b0, 1'b1, st, 1'b0, 1'b0, 8'h00, 8'h00));
            if (i == rst_at) begin
                m_ir    = 8'h00;
                m_fault = 1'b0;
                mode    = MD_IDLE;
                return;
            end
        end
        if (w + 1 > TIMEOUT) begin
            m_fault = 1'b1;
            mode    = MD_HALT;
            return;
        end
        if (!st)
            cyc("wb", 1'b0, rb(), rbyte(), pcv, rb(), rb(),
                ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00));
        mode = MD_FETCH;
    endtask

    // Bring the model to a DECODE cycle from wherever it is, then execute
    task automatic issue(input logic [7:0] ins, input logic [7:0] pcv, input int w,
                         input int rst_at, input int halt_wait);
        if (mode == MD_HALT) begin
            if (m_fault) fault_recover();
            else         halt_phase(halt_wait);
        end
        if (mode == MD_IDLE) idle_phase(1);
        if (mode == MD_FETCH) fetch_phase();
        exec_instr(ins, pcv, w, rst_at);
    endtask

    initial begin
        int w;
        int ra;
        logic [7:0] ins;
        m_ir          = 8'h00;
        m_fault       = 1'b0;
        mode          = MD_IDLE;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.inscode   = 8'h00;
        bus.pc        = 8'h00;
        bus.alu_done  = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        cyc("reset", 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, quiet());
        cyc("reset_rel", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, quiet());

        issue(8'h05, 8'h01, 0, 0, 1);      // ALU, done right after alu_start
        issue(8'h8A, 8'h02, 3, 0, 1);      // STORE, ready low 3 cycles
        issue(8'hC7, 8'h85, 0, 0, 1);      // JUMP straight into DECODE
        issue(8'h42, 8'hC3, 0, 0, 1);      // LOAD, ready in first MEM cycle
        issue(8'h05, 8'h04, 14, 0, 1);     // ALU done in the TIMEOUT cycle
        issue(8'h42, 8'h05, 14, 0, 1);     // LOAD ready in the TIMEOUT cycle
        issue(8'h3F, 8'h10, 0, 0, 1);      // HALT
        issue(8'h42, 8'h11, 100, 0, 4);    // resume after 4 cycles; LOAD times out
        issue(8'h1C, 8'h12, 1, 0, 1);      // fault blocks run, reset recovers
        issue(8'h42, 8'h20, 10, 3, 1);     // reset in MEM with mem_req high

        for (int n = 0; n < 80; n++) begin
            ins = ($urandom_range(0, 9) == 0) ? 8'h3F : rbyte();
            w   = ($urandom_range(0, 11) == 0) ? 16 + $urandom_range(0, 4)
                                               : $urandom_range(0, 5);
            ra  = ($urandom_range(0, 14) == 0)
                  ? $urandom_range(1, (w + 1 > TIMEOUT) ? TIMEOUT : w + 1) : 0;
            issue(ins, rbyte(), w, ra, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
